// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer: walks FETCH..WB per instruction, gates
// per-stage enables, counts retired instructions and traps memory timeouts into HALT.
//
// state  | meaning
// IDLE   | waiting for I_run
// FETCH  | instruction fetch, waits on I_mem_ready
// DECODE | decode, latches instruction class
// REGRD  | register-file read
// EXEC   | ALU operation
// MEM    | data access for LOAD/STORE, waits on I_mem_ready
// WB     | writeback and PC update, retires the instruction
// HALT   | halted (halt request or memory timeout), exits only via reset
module stage_sequencer (
  input  logic        clk,
  input  logic        I_reset,
  input  logic        I_run,
  input  logic        I_mem_ready,
  input  logic [1:0]  I_opclass,
  input  logic        I_stall,
  input  logic        I_halt,
  output logic        O_enpc,
  output logic        O_enmem,
  output logic        O_endec,
  output logic        O_enrg,
  output logic        O_enalu,
  output logic        O_enwb,
  output logic [2:0]  O_state,
  output logic [15:0] O_instret,
  output logic        O_halted,
  output logic        O_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_REGRD  = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [1:0] CLS_ALU   = 2'b00;
  localparam logic [1:0] CLS_LOAD  = 2'b01;
  localparam logic [1:0] CLS_STORE = 2'b10;

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [1:0]  class_q, class_d;
  logic [15:0] instret_q, instret_d;
  logic        err_q, err_d;
  logic        stalled;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    class_d   = class_q;
    instret_d = instret_q;
    err_d     = err_q;
    O_enpc    = 1'b0;
    O_enmem   = 1'b0;
    O_endec   = 1'b0;
    O_enrg    = 1'b0;
    O_enalu   = 1'b0;
    O_enwb    = 1'b0;
    stalled   = I_stall && (state_q inside {S_DECODE, S_REGRD, S_EXEC, S_WB});

    if (!stalled) begin
      case (state_q)
        S_IDLE: if (I_run) state_d = S_FETCH;
        S_FETCH, S_MEM: begin
          O_enmem = 1'b1;
          // A ready on the 16th not-ready slot still wins over the timeout
          if (I_mem_ready) begin
            state_d = (state_q == S_FETCH) ? S_DECODE : S_WB;
          end else if (wait_q == 4'hF) begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end else begin
            wait_d = wait_q + 4'd1;
          end
        end
        S_DECODE: begin
          O_endec = 1'b1;
          class_d = I_opclass;
          state_d = S_REGRD;
        end
        S_REGRD: begin
          O_enrg  = 1'b1;
          state_d = S_EXEC;
        end
        S_EXEC: begin
          O_enalu = 1'b1;
          state_d = (class_q == CLS_LOAD || class_q == CLS_STORE) ? S_MEM : S_WB;
        end
        S_WB: begin
          O_enpc    = 1'b1;
          O_enwb    = (class_q == CLS_ALU || class_q == CLS_LOAD);
          instret_d = instret_q + 16'd1;
          if (I_halt)     state_d = S_HALT;
          else if (I_run) state_d = S_FETCH;
          else            state_d = S_IDLE;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end

    // Any state change starts the next memory wait from zero
    if (state_d != state_q) wait_d = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (I_reset) begin
      state_q   <= S_IDLE;
      wait_q    <= 4'd0;
      class_q   <= 2'b00;
      instret_q <= 16'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      class_q   <= class_d;
      instret_q <= instret_d;
      err_q     <= err_d;
    end
  end

  assign O_state   = state_q;
  assign O_instret = instret_q;
  assign O_halted  = (state_q == S_HALT);
  assign O_err     = err_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a behavioural model.
module tb_stage_sequencer;

  logic        clk = 1'b0;
  logic        I_reset = 1'b1, I_run = 1'b0, I_mem_ready = 1'b0, I_stall = 1'b0, I_halt = 1'b0;
  logic [1:0]  I_opclass = 2'b00;
  logic        O_enpc, O_enmem, O_endec, O_enrg, O_enalu, O_enwb, O_halted, O_err;
  logic [2:0]  O_state;
  logic [15:0] O_instret;

  int vectors = 0;
  int miscompares = 0;

  stage_sequencer dut (
    .clk(clk), .I_reset(I_reset), .I_run(I_run), .I_mem_ready(I_mem_ready),
    .I_opclass(I_opclass), .I_stall(I_stall), .I_halt(I_halt),
    .O_enpc(O_enpc), .O_enmem(O_enmem), .O_endec(O_endec), .O_enrg(O_enrg),
    .O_enalu(O_enalu), .O_enwb(O_enwb), .O_state(O_state), .O_instret(O_instret),
    .O_halted(O_halted), .O_err(O_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: stage number, consecutive not-ready count, retired count
  int m_st = 0, m_notready = 0, m_ret = 0;
  int m_cls = 0;
  bit m_err = 0, m_valid = 0;

  always @(posedge clk) begin
    if (I_reset) begin
      m_st = 0; m_notready = 0; m_ret = 0; m_cls = 0; m_err = 0; m_valid = 1;
    end else if (m_valid) begin
      if (I_stall && (m_st == 2 || m_st == 3 || m_st == 4 || m_st == 6)) begin
        // frozen
      end else if (m_st == 0) begin
        if (I_run) m_st = 1;
      end else if (m_st == 1 || m_st == 5) begin
        if (I_mem_ready) begin
          m_st = (m_st == 1) ? 2 : 6;
          m_notready = 0;
        end else begin
          m_notready++;
          if (m_notready == 16) begin m_st = 7; m_err = 1; m_notready = 0; end
        end
      end else if (m_st == 2) begin
        m_cls = int'(I_opclass); m_st = 3;
      end else if (m_st == 3) begin
        m_st = 4;
      end else if (m_st == 4) begin
        m_st = (m_cls == 1 || m_cls == 2) ? 5 : 6;
      end else if (m_st == 6) begin
        m_ret = (m_ret + 1) % 65536;
        m_st = I_halt ? 7 : (I_run ? 1 : 0);
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (m_valid) begin
      automatic bit live = !(I_stall && (m_st == 2 || m_st == 3 || m_st == 4 || m_st == 6));
      automatic bit [5:0] exp_en, act_en;
      exp_en[5] = live && m_st == 6;
      exp_en[4] = (m_st == 1 || m_st == 5);
      exp_en[3] = live && m_st == 2;
      exp_en[2] = live && m_st == 3;
      exp_en[1] = live && m_st == 4;
      exp_en[0] = live && m_st == 6 && (m_cls == 0 || m_cls == 1);
      act_en = {O_enpc, O_enmem, O_endec, O_enrg, O_enalu, O_enwb};
      vectors++;
      if ($isunknown({O_state, O_instret, O_halted, O_err, act_en}) ||
          int'(O_state) != m_st || int'(O_instret) != m_ret ||
          O_halted != (m_st == 7) || O_err != m_err || act_en != exp_en) begin
        miscompares++;
        $display("FAIL model: got st=%0d ret=%0d hlt=%b err=%b en=%b expected st=%0d ret=%0d hlt=%b err=%b en=%b at %0t",
                 O_state, O_instret, O_halted, O_err, act_en,
                 m_st, m_ret, (m_st == 7), m_err, exp_en, $time);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    I_reset = 1; I_run = 0; I_mem_ready = 0; I_stall = 0; I_halt = 0; I_opclass = 2'b00;
    step(2);
    I_reset = 0;
  endtask

  initial begin
    int ready_pct;

    // Reset state and straight-line ALU flow
    do_reset();
    #1;
    cmp("reset_state", O_state, 0);
    cmp("reset_instret", O_instret, 0);
    cmp("reset_en", {O_enpc, O_enmem, O_endec, O_enrg, O_enalu, O_enwb}, 0);
    I_run = 1; I_mem_ready = 1; I_opclass = 2'b00;
    step(); cmp("alu_fetch", O_state, 1);
    step(); cmp("alu_decode", O_state, 2);
    step(); cmp("alu_regrd", O_state, 3);
    step(); cmp("alu_exec", O_state, 4);
    cmp("alu_exec_enpc", O_enpc, 0);
    step(); cmp("alu_wb", O_state, 6);
    cmp("alu_wb_enpc", O_enpc, 1); cmp("alu_wb_enwb", O_enwb, 1);
    step(); cmp("alu_refetch", O_state, 1);
    cmp("alu_instret", O_instret, 1);

    // LOAD with three not-ready MEM cycles
    do_reset();
    I_run = 1; I_mem_ready = 1; I_opclass = 2'b01;
    step(4);
    I_mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step(); cmp("load_mem_wait", O_state, 5); cmp("load_mem_en", O_enmem, 1);
    end
    I_mem_ready = 1;
    #1; cmp("load_mem_last", O_state, 5);
    step(); cmp("load_wb", O_state, 6); cmp("load_wb_enwb", O_enwb, 1); cmp("load_err", O_err, 0);

    // Fetch timeout
    do_reset();
    I_run = 1; I_mem_ready = 0;
    step();
    for (int i = 0; i < 16; i++) begin
      cmp("timeout_fetch", O_state, 1);
      step();
    end
    cmp("timeout_state", O_state, 7); cmp("timeout_halted", O_halted, 1); cmp("timeout_err", O_err, 1);
    I_mem_ready = 1;
    step(); cmp("timeout_absorb", O_state, 7);

    // Stall in EXEC
    do_reset();
    I_run = 1; I_mem_ready = 1; I_opclass = 2'b00;
    step(4);
    I_stall = 1;
    #1; cmp("stall_exec1", O_state, 4); cmp("stall_alu1", O_enalu, 0);
    step(); cmp("stall_exec2", O_state, 4); cmp("stall_alu2", O_enalu, 0);
    step(); I_stall = 0;
    #1; cmp("stall_exec3", O_state, 4); cmp("stall_alu3", O_enalu, 1);
    step(); cmp("stall_wb", O_state, 6);

    // Reset during the second MEM wait cycle after one retired instruction
    do_reset();
    I_run = 1; I_mem_ready = 1; I_opclass = 2'b00;
    step(6);
    cmp("rst_pre_ret", O_instret, 1);
    I_opclass = 2'b01;
    step(3);
    I_mem_ready = 0;
    step(2); cmp("rst_in_mem", O_state, 5);
    I_reset = 1;
    step();
    cmp("rst_state", O_state, 0); cmp("rst_instret", O_instret, 0);
    cmp("rst_en", {O_enpc, O_enmem, O_endec, O_enrg, O_enalu, O_enwb}, 0);
    I_reset = 0;

    // Halt vs stall in WB
    do_reset();
    I_run = 1; I_mem_ready = 1; I_opclass = 2'b10;
    step(6);
    I_halt = 1; I_stall = 1;
    #1; cmp("halt_stall_wb", O_state, 6);
    step(); cmp("halt_stall_hold", O_state, 6); cmp("halt_stall_ret", O_instret, 0);
    I_stall = 0;
    step(); cmp("halt_state", O_state, 7); cmp("halt_ret", O_instret, 1); cmp("halt_flag", O_halted, 1);

    // Randomized traffic
    do_reset();
    ready_pct = 100;
    for (int c = 0; c < 6000; c++) begin
      if (c % 120 == 0) begin
        case ($urandom_range(0, 3))
          0: ready_pct = 100;
          1: ready_pct = 75;
          2: ready_pct = 25;
          default: ready_pct = 3;
        endcase
      end
      I_reset     = ($urandom_range(0, 249) == 0);
      I_run       = ($urandom_range(0, 9) != 0);
      I_mem_ready = ($urandom_range(0, 99) < ready_pct);
      I_stall     = ($urandom_range(0, 4) == 0);
      I_halt      = ($urandom_range(0, 49) == 0);
      I_opclass   = 2'($urandom_range(0, 3));
      if (O_halted && $urandom_range(0, 7) == 0) I_reset = 1;
      step();
    end

    I_reset = 0;
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); I_reset input 1 (synchronous, active-high reset).
REQ-002 SHALL have these inputs:
- I_run, 1 bit: level; permits the sequencer to leave IDLE and to continue after WB.
- I_mem_ready, 1 bit: memory handshake; the access completes on the cycle it is high in FETCH or MEM.
- I_opclass, 2 bits: instruction class from the decoder (00 ALU, 01 LOAD, 10 STORE, 11 BRANCH).
- I_stall, 1 bit: hazard stall request.
- I_halt, 1 bit: halt request, sampled in WB.
REQ-003 SHALL have these enable outputs, 1 bit each:
- O_enpc: PC update.
- O_enmem: memory access (instruction fetch or data).
- O_endec: decoder.
- O_enrg: register-file read.
- O_enalu: ALU.
- O_enwb: register-file writeback.
REQ-004 SHALL have these status outputs:
- O_state, 3 bits: current state encoding.
- O_instret, 16 bits: retired-instruction count.
- O_halted, 1 bit: the sequencer is in HALT.
- O_err, 1 bit: sticky memory-timeout flag.

Function
REQ-005 States and encodings SHALL be IDLE=0, FETCH=1, DECODE=2, REGRD=3, EXEC=4, MEM=5, WB=6, HALT=7.
REQ-006 Enables SHALL decode from the current state:
- FETCH: O_enmem.
- DECODE: O_endec.
- REGRD: O_enrg.
- EXEC: O_enalu.
- MEM: O_enmem.
- WB: O_enpc, plus O_enwb when the latched class is ALU or LOAD.
- All other enables SHALL be 0.
REQ-007 IDLE SHALL go to FETCH on the cycle after I_run=1 is sampled; otherwise IDLE SHALL hold.
REQ-008 FETCH and MEM SHALL advance only when I_mem_ready=1: FETCH goes to DECODE and MEM goes to WB; otherwise the state holds with O_enmem held at 1.
REQ-009 A 4-bit wait counter SHALL clear on entry to FETCH or MEM and increment on each cycle in FETCH or MEM with I_mem_ready=0.
REQ-010 In FETCH or MEM with I_mem_ready=0 and wait counter=15 (the 16th consecutive not-ready cycle), the next state SHALL be HALT and O_err SHALL set; I_mem_ready=1 on that same cycle SHALL win, with normal advance and no error.
REQ-011 DECODE SHALL go to REGRD, and I_opclass SHALL be latched into an internal 2-bit class register on the DECODE exit edge.
REQ-012 REGRD SHALL go to EXEC.
REQ-013 EXEC SHALL go to MEM when the latched class is LOAD or STORE, and to WB otherwise.
REQ-014 WB SHALL increment O_instret by 1 (0xFFFF wraps to 0x0000), then go to:
- HALT if I_halt=1;
- else FETCH if I_run=1;
- else IDLE.
- I_halt SHALL take priority over I_run.
REQ-015 I_stall=1 in DECODE, REGRD, EXEC or WB SHALL hold the state and force all enables to 0 that cycle; O_instret SHALL not increment and I_halt/I_run SHALL not be acted on.
REQ-016 I_stall SHALL be ignored in IDLE, FETCH, MEM and HALT.
REQ-017 HALT SHALL be absorbing until I_reset, with O_halted=1 and all enables 0.
REQ-018 O_err SHALL remain set until I_reset.
REQ-019 Minimum latency SHALL be 5 cycles per ALU or BRANCH instruction and 6 per LOAD or STORE, with zero memory wait and no stall.

Reset
REQ-020 I_reset=1 at a rising edge SHALL force, on the next cycle regardless of current state (including mid-MEM wait or HALT):
- state IDLE;
- all enables 0;
- O_instret=0, wait counter=0, class register=00;
- O_err=0, O_halted=0.
REQ-021 I_reset SHALL take priority over every other input.

Verification
REQ-022 Reset, then I_run=1, I_opclass=00, I_mem_ready=1 constantly -> O_state sequence 0,1,2,3,4,6,1; O_enpc=1 and O_enwb=1 only in the WB cycle; O_instret=1 after the first WB.
REQ-023 LOAD (01), with I_mem_ready low for 3 MEM cycles then high -> MEM occupies 4 cycles with O_enmem=1 throughout; WB has O_enwb=1; O_err=0.
REQ-024 FETCH with I_mem_ready held 0 -> 16 FETCH cycles, then O_state=7, O_halted=1, O_err=1; a subsequent I_mem_ready=1 has no effect.
REQ-025 I_stall=1 for 2 cycles during EXEC -> O_state stays 4 for 3 cycles total; O_enalu=0 on the two stalled cycles and 1 on the third.
REQ-026 I_reset=1 during the second MEM wait cycle -> the next cycle has O_state=0, all enables 0, O_instret=0.
REQ-027 I_halt=1 in WB with I_run=1 -> O_state=7 and O_instret incremented; I_halt=1 concurrent with I_stall=1 -> stays in WB with no increment.
